tgl_hs_receiver: RTL
====================

Name: tgl_hs_receiver

Overview:
- Receiving end of a toggle-based request/acknowledge handshake: the peer transmitter flips req_tgl once per transfer and holds req_data stable until it sees ack_tgl flip back.
- The block synchronises req_tgl, detects each toggle, captures the data word and presents it on a valid/ready consumer port.
- Once the consumer accepts the word, the block toggles ack_tgl and counts the completed transfer.
- It sits between a toggle-signalling producer (T-flip-flop style request line) and local logic in the clk domain.

Parameters:
DATA_W, 8, width of req_data/out_data
SYNC_STAGES, 2, flops in the req_tgl synchroniser chain (min 2)
CNT_W, 8, width of completed-transfer counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  reset, synchronous, active-high
req_tgl  input  1  request toggle from transmitter; each level change = one transfer
req_data  input  DATA_W  payload; stable from req_tgl toggle until ack_tgl toggle
ack_tgl  output  1  acknowledge toggle back to transmitter
out_valid  output  1  captured word available
out_data  output  DATA_W  captured word; stable while out_valid=1
out_ready  input  1  consumer accepts word when out_valid & out_ready at a rising edge
event_cnt  output  CNT_W  completed transfers, wraps modulo 2^CNT_W
overflow  output  1  sticky: toggle detected while previous word still pending
clr_ovf  input  1  clears overflow

Behaviour:
- Reset (reset=1 at a rising edge) clears all registers:
  - sync chain = 0, req_prev = 0, ack_tgl = 0, out_valid = 0, out_data = 0, event_cnt = 0, overflow = 0, state = IDLE.
  - Reset mid-transfer discards the pending word with no ack; the transmitter must be reset together with this block, so req_tgl = 0 at reset release.
- Synchroniser and edge detect:
  - req_tgl shifts through SYNC_STAGES flops; req_sync = last stage.
  - edge = req_sync XOR req_prev (combinational).
  - req_prev <= req_sync on every edge it is consumed (IDLE capture or VALID drop).
- Latency: let E0 be the first rising edge sampling the new req_tgl level. out_valid rises after edge E0+SYNC_STAGES (2 edges later with the default).
- State IDLE:
  - out_valid = 0.
  - If edge=1: out_data <= req_data, req_prev <= req_sync, out_valid <= 1, go VALID.
- State VALID:
  - out_valid = 1; out_data held.
  - If out_ready=1: out_valid <= 0, ack_tgl <= ~ack_tgl, event_cnt <= event_cnt+1 (wraps), go IDLE.
  - If edge=1 (protocol violation): overflow <= 1, req_prev <= req_sync, and the new toggle is dropped (no capture, no ack, no count). This applies even when out_ready=1 in the same cycle: the current word still completes and the new toggle is dropped.
- Back-to-back transfers:
  - Accept and ack happen on the same edge, so the next word can be captured no earlier than SYNC_STAGES edges after the transmitter sees the ack and retoggles.
  - Minimum one IDLE cycle between words.
- overflow: set has priority over clr_ovf in the same cycle; otherwise clr_ovf=1 clears it.
- event_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- out_ready while IDLE is ignored.
- ack_tgl changes only on accepted words and never while reset=1.

Test Plan:
- Reset, then hold req_tgl=0, 10 cycles -> out_valid=0, ack_tgl=0, event_cnt=0, overflow=0.
- req_data=0xA5, req_tgl 0->1 at edge E0, out_ready=1 -> out_valid=1 only in the cycle after E0+2 with out_data=0xA5, ack_tgl=1 after next edge, event_cnt=1.
- req_data=0x3C toggle with out_ready=0 for 5 cycles, then 1 -> out_valid held 5 cycles, out_data=0x3C stable, ack_tgl flips only on the accept edge, event_cnt increments once.
- Second req_tgl toggle while VALID with out_ready=0 -> overflow=1, word unchanged, one ack and count total. clr_ovf=1 then sets overflow=0. Overflow with clr_ovf in the same cycle -> overflow stays 1.
- 256 complete transfers with CNT_W=8 -> event_cnt wraps to 0 and ack_tgl has toggled 256 times (ends at 0).
- Reset asserted while VALID with pending 0x77 -> next cycle out_valid=0, ack_tgl=0, event_cnt=0, no ack toggle emitted.

Source files
------------

// File: rtl/tgl_hs_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tgl_hs_receiver
//  Purpose  : Receiving end of a toggle request/acknowledge handshake.
//             req_tgl is synchronised into clk, each level change is detected
//             and the accompanying req_data word is captured. The word is
//             offered on a valid/ready port, and accepting it flips ack_tgl
//             and bumps a wrapping transfer counter. A toggle that arrives
//             while a word is still pending is dropped and flagged in a
//             sticky overflow bit.
//  Ports    :
//    clk        in   clock, rising edge
//    reset      in   synchronous active-high reset
//    req_tgl    in   request toggle from the transmitter (asynchronous)
//    req_data   in   payload, stable from req_tgl toggle until ack_tgl toggle
//    ack_tgl    out  acknowledge toggle back to the transmitter
//    out_valid  out  captured word available
//    out_data   out  captured word, stable while out_valid=1
//    out_ready  in   consumer accepts the word when out_valid & out_ready
//    event_cnt  out  completed transfers, wraps modulo 2^CNT_W
//    overflow   out  sticky: toggle seen while a word was still pending
//    clr_ovf    in   clears overflow (a same-cycle set wins)
//  Revision : 1.0  initial release
// ============================================================================
module tgl_hs_receiver #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  event_cnt,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_VALID = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_prev;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_req_sync;
    logic                   w_edge;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_ovf_set;
    logic                   r_ack_tgl;
    logic [DATA_W-1:0]      r_out_data;
    logic [CNT_W-1:0]       r_event_cnt;
    logic                   r_overflow;

    // ------------------------------------------------------------------
    // Synchroniser: stage 0 samples the asynchronous request line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_tgl};
        end
    end

    assign w_req_sync = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_req_sync ^ r_req_prev;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_edge)    w_state_nxt = c_VALID;
            c_VALID: if (out_ready) w_state_nxt = c_IDLE;
            default:                w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        w_ovf_set = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_capture = w_edge;
            end
            c_VALID: begin
                out_valid = 1'b1;
                w_accept  = out_ready;
                // A toggle while pending is a protocol violation: it is
                // consumed (so it is not seen again) but never captured.
                w_ovf_set = w_edge;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_prev  <= 1'b0;
            r_out_data  <= '0;
            r_ack_tgl   <= 1'b0;
            r_event_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_capture || w_ovf_set) begin
                r_req_prev <= w_req_sync;
            end
            if (w_capture) begin
                r_out_data <= req_data;
            end
            if (w_accept) begin
                r_ack_tgl   <= ~r_ack_tgl;
                r_event_cnt <= r_event_cnt + CNT_W'(1);
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign ack_tgl   = r_ack_tgl;
    assign out_data  = r_out_data;
    assign event_cnt = r_event_cnt;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
